// File: rtl/axi_ar_arbiter_encoder_if.sv
// AR-channel signal bundle between the two CPU masters, the six slaves and the R-channel decoder.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric's view.
interface axi_ar_arbiter_encoder_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int NSLV   = 7
);
  // Handshake: a transfer happens on a rising ACLK edge where VALID and READY are both high.
  // VALID never waits for READY; payload is meaningful only while VALID is high.
  logic [ID_W-1:0]   ARID_M0,    ARID_M1;
  logic [ADDR_W-1:0] ARADDR_M0,  ARADDR_M1;
  logic [3:0]        ARLEN_M0,   ARLEN_M1;
  logic [2:0]        ARSIZE_M0,  ARSIZE_M1;
  logic [1:0]        ARBURST_M0, ARBURST_M1;
  logic              ARVALID_M0, ARVALID_M1;
  logic              ARREADY_M0, ARREADY_M1;
  logic [ID_W+3:0]   ARID_S;
  logic [ADDR_W-1:0] ARADDR_S;
  logic [3:0]        ARLEN_S;
  logic [2:0]        ARSIZE_S;
  logic [1:0]        ARBURST_S;
  logic [NSLV-1:0]   ARVALID_S;
  logic [NSLV-1:0]   ARREADY_S;
  logic              RVALID, RREADY, RLAST;
  logic              R_OWNER;
  logic [2:0]        R_SEL;
  logic              BUSY, LEN_ERR;
  logic [1:0]        state_dbg;

  modport slave (
    input  ARID_M0, ARID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
           ARSIZE_M0, ARSIZE_M1, ARBURST_M0, ARBURST_M1, ARVALID_M0, ARVALID_M1,
           ARREADY_S, RVALID, RREADY, RLAST,
    output ARREADY_M0, ARREADY_M1, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
           ARVALID_S, R_OWNER, R_SEL, BUSY, LEN_ERR, state_dbg
  );

  modport master (
    output ARID_M0, ARID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
           ARSIZE_M0, ARSIZE_M1, ARBURST_M0, ARBURST_M1, ARVALID_M0, ARVALID_M1,
           ARREADY_S, RVALID, RREADY, RLAST,
    input  ARREADY_M0, ARREADY_M1, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
           ARVALID_S, R_OWNER, R_SEL, BUSY, LEN_ERR, state_dbg
  );
endinterface

// File: rtl/axi_ar_arbiter_encoder.sv
// Read-address arbiter/decoder for the 2-master/6-slave bridge: grants one master,
// forwards its AR to the decoded slave and holds the path until the RLAST handshake.
module axi_ar_arbiter_encoder #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int NSLV   = 7
) (
  input logic                     ACLK,
  input logic                     ARESET,
  axi_ar_arbiter_encoder_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [2:0]  sel_q, sel_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  beat_q, beat_d;
  logic [3:0]  len_q, len_d;
  logic        len_err_q, len_err_d;
  logic        pick;

  logic              own_valid;
  logic [ID_W-1:0]   own_id;
  logic [ADDR_W-1:0] own_addr;
  logic [3:0]        own_len;
  logic [2:0]        own_size;
  logic [1:0]        own_burst;
  logic              r_hs;

  function automatic logic [2:0] decode(input logic [ADDR_W-1:0] a);
    if (a[31:14] == 18'h0)                 decode = 3'd0;
    else if (a[31:16] == 16'h0001)         decode = 3'd1;
    else if (a[31:16] == 16'h0002)         decode = 3'd2;
    else if (a[31:10] == 22'h04_0000)      decode = 3'd3;
    else if (a[31:10] == 22'h04_0040)      decode = 3'd4;
    else if (a[31:21] == 11'h100)          decode = 3'd5;
    else                                   decode = 3'd6;
  endfunction

  always_comb begin
    own_valid = owner_q ? bus.ARVALID_M1 : bus.ARVALID_M0;
    own_id    = owner_q ? bus.ARID_M1    : bus.ARID_M0;
    own_addr  = owner_q ? bus.ARADDR_M1  : bus.ARADDR_M0;
    own_len   = owner_q ? bus.ARLEN_M1   : bus.ARLEN_M0;
    own_size  = owner_q ? bus.ARSIZE_M1  : bus.ARSIZE_M0;
    own_burst = owner_q ? bus.ARBURST_M1 : bus.ARBURST_M0;
    r_hs      = bus.RVALID && bus.RREADY;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      sel_q        <= 3'd0;
      last_grant_q <= 1'b1;
      beat_q       <= 4'd0;
      len_q        <= 4'd0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
      len_q        <= len_d;
      len_err_q    <= len_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    sel_d          = sel_q;
    last_grant_d   = last_grant_q;
    beat_d         = beat_q;
    len_d          = len_q;
    len_err_d      = 1'b0;
    pick           = 1'b0;
    bus.ARID_S     = '0;
    bus.ARADDR_S   = '0;
    bus.ARLEN_S    = '0;
    bus.ARSIZE_S   = '0;
    bus.ARBURST_S  = '0;
    bus.ARVALID_S  = '0;
    bus.ARREADY_M0 = 1'b0;
    bus.ARREADY_M1 = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ARVALID_M0 || bus.ARVALID_M1) begin
          // On a tie the master that did not win last time gets the bus.
          pick    = (bus.ARVALID_M0 && bus.ARVALID_M1) ? ~last_grant_q : bus.ARVALID_M1;
          owner_d = pick;
          sel_d   = decode(pick ? bus.ARADDR_M1 : bus.ARADDR_M0);
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        bus.ARID_S           = {(owner_q ? 4'b0010 : 4'b0001), own_id};
        bus.ARADDR_S         = own_addr;
        bus.ARLEN_S          = own_len;
        bus.ARSIZE_S         = own_size;
        bus.ARBURST_S        = own_burst;
        bus.ARVALID_S[sel_q] = own_valid;
        if (owner_q) bus.ARREADY_M1 = bus.ARREADY_S[sel_q];
        else         bus.ARREADY_M0 = bus.ARREADY_S[sel_q];
        if (own_valid && bus.ARREADY_S[sel_q]) begin
          len_d        = own_len;
          beat_d       = 4'd0;
          last_grant_d = owner_q;
          state_d      = S_DATA;
        end
      end
      S_DATA: begin
        if (r_hs) begin
          beat_d = beat_q + 4'd1;
          if (bus.RLAST) begin
            len_err_d = (beat_q != len_q);
            owner_d   = 1'b0;
            sel_d     = 3'd0;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.BUSY      = (state_q != S_IDLE);
  assign bus.R_OWNER   = owner_q;
  assign bus.R_SEL     = sel_q;
  assign bus.LEN_ERR   = len_err_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_axi_ar_arbiter_encoder.sv
// Directed and randomized bursts through the AR arbiter, checked against a transaction-level
// model of arbitration fairness, the address map and the RLAST length rule.
module tb_axi_ar_arbiter_encoder;
  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  axi_ar_arbiter_encoder_if bus ();
  axi_ar_arbiter_encoder dut (.ACLK(ACLK), .ARESET(ARESET), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  int last_winner;
  logic [48:0] exp_q[$];

  logic [3:0]  f_id[2];
  logic [31:0] f_addr[2];
  logic [3:0]  f_len[2];
  logic [2:0]  f_size[2];
  logic [1:0]  f_burst[2];

  logic [31:0] addr_tab [0:17] = '{
    32'h0000_0000, 32'h0000_3FFC, 32'h0000_4000, 32'h0001_0000, 32'h0001_FFFF, 32'h0002_0000,
    32'h0002_FFFF, 32'h0003_0000, 32'h1000_0000, 32'h1000_03FF, 32'h1000_0400, 32'h1001_0000,
    32'h1001_03FF, 32'h1001_0400, 32'h2000_0000, 32'h201F_FFFF, 32'h2020_0000, 32'hFFFF_FFFF};

  // ---------------- clock / reset ----------------
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    last_winner = 1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int ref_sel(input logic [31:0] a);
    if (a <= 32'h0000_3FFF) return 0;
    if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) return 1;
    if (a >= 32'h0002_0000 && a <= 32'h0002_FFFF) return 2;
    if (a >= 32'h1000_0000 && a <= 32'h1000_03FF) return 3;
    if (a >= 32'h1001_0000 && a <= 32'h1001_03FF) return 4;
    if (a >= 32'h2000_0000 && a <= 32'h201F_FFFF) return 5;
    return 6;
  endfunction

  function automatic logic [48:0] ref_payload(input int m);
    logic [3:0] tag;
    tag = (m == 1) ? 4'b0010 : 4'b0001;
    return {tag, f_id[m], f_addr[m], f_len[m], f_size[m], f_burst[m]};
  endfunction

  function automatic logic [48:0] dut_payload();
    return {bus.ARID_S, bus.ARADDR_S, bus.ARLEN_S, bus.ARSIZE_S, bus.ARBURST_S};
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    bus.ARID_M0 = '0; bus.ARADDR_M0 = '0; bus.ARLEN_M0 = '0; bus.ARSIZE_M0 = '0;
    bus.ARBURST_M0 = '0; bus.ARVALID_M0 = 1'b0;
    bus.ARID_M1 = '0; bus.ARADDR_M1 = '0; bus.ARLEN_M1 = '0; bus.ARSIZE_M1 = '0;
    bus.ARBURST_M1 = '0; bus.ARVALID_M1 = 1'b0;
    bus.ARREADY_S = '0; bus.RVALID = 1'b0; bus.RREADY = 1'b0; bus.RLAST = 1'b0;
  endtask

  task automatic set_m(input int m, input logic [3:0] id, input logic [31:0] addr,
                       input logic [3:0] len);
    f_id[m]    = id;
    f_addr[m]  = addr;
    f_len[m]   = len;
    f_size[m]  = 3'($urandom_range(0, 7));
    f_burst[m] = 2'($urandom_range(0, 2));
  endtask

  task automatic apply_fields();
    bus.ARID_M0 = f_id[0]; bus.ARADDR_M0 = f_addr[0]; bus.ARLEN_M0 = f_len[0];
    bus.ARSIZE_M0 = f_size[0]; bus.ARBURST_M0 = f_burst[0];
    bus.ARID_M1 = f_id[1]; bus.ARADDR_M1 = f_addr[1]; bus.ARLEN_M1 = f_len[1];
    bus.ARSIZE_M1 = f_size[1]; bus.ARBURST_M1 = f_burst[1];
  endtask

  task automatic set_valid(input int m, input logic v);
    if (m == 1) bus.ARVALID_M1 = v;
    else        bus.ARVALID_M0 = v;
  endtask

  // One complete burst: IDLE request cycle, ADDR phase with rdy_delay stalls,
  // DATA phase with random R gaps and RLAST on handshake index rlast_at.
  // abort_at >= 0 pulses ARESET after that many DATA cycles instead.
  task automatic burst(input logic req0, input logic req1, input int rdy_delay,
                       input int rlast_at, input int abort_at);
    int w, sel, hs, cycles;
    logic done, exp_err;
    logic [48:0] exp_pl;
    logic [63:0] exp_vs;
    w   = (req0 && req1) ? (1 - last_winner) : (req1 ? 1 : 0);
    sel = ref_sel(f_addr[w]);
    exp_q.push_back(ref_payload(w));
    apply_fields();
    bus.ARVALID_M0 = req0;
    bus.ARVALID_M1 = req1;
    bus.ARREADY_S  = '0;
    @(negedge ACLK);
    chk("idle_busy", 64'(bus.BUSY), 64'd0);
    chk("idle_arvalid_s", 64'(bus.ARVALID_S), 64'd0);
    chk("idle_arready_m", 64'({bus.ARREADY_M1, bus.ARREADY_M0}), 64'd0);
    chk("idle_payload", 64'(dut_payload()), 64'd0);
    chk("idle_len_err", 64'(bus.LEN_ERR), 64'd0);
    step();

    exp_pl = exp_q.pop_front();
    for (int i = 0; i <= rdy_delay; i++) begin
      if (i == rdy_delay) bus.ARREADY_S = 7'(32'd1 << sel);
      if (rdy_delay >= 3) set_valid(w, (i != 1));
      exp_vs = (rdy_delay >= 3 && i == 1) ? 64'd0 : (64'd1 << sel);
      @(negedge ACLK);
      chk("addr_arvalid_s", 64'(bus.ARVALID_S), exp_vs);
      chk("addr_payload", 64'(dut_payload()), 64'(exp_pl));
      chk("addr_arready_m", 64'({bus.ARREADY_M1, bus.ARREADY_M0}),
          (i == rdy_delay) ? ((w == 1) ? 64'd2 : 64'd1) : 64'd0);
      chk("addr_owner", 64'({bus.BUSY, bus.R_OWNER, bus.R_SEL}),
          64'({1'b1, w[0], sel[2:0]}));
      step();
    end
    set_valid(w, 1'b0);
    bus.ARREADY_S = '0;

    hs = 0; cycles = 0; done = 1'b0;
    while (!done && cycles < 300) begin
      if (abort_at >= 0 && cycles == abort_at) begin
        ARESET = 1'b1;
        bus.RVALID = 1'b0; bus.RLAST = 1'b0;
        bus.ARVALID_M0 = 1'b0; bus.ARVALID_M1 = 1'b0;
        step();
        ARESET = 1'b0;
        last_winner = 1;
        @(negedge ACLK);
        chk("abort_busy", 64'(bus.BUSY), 64'd0);
        chk("abort_arvalid_s", 64'(bus.ARVALID_S), 64'd0);
        chk("abort_owner_sel_err", 64'({bus.R_OWNER, bus.R_SEL, bus.LEN_ERR}), 64'd0);
        step();
        return;
      end
      bus.RVALID = ($urandom_range(0, 3) != 0);
      bus.RREADY = ($urandom_range(0, 3) != 0);
      bus.RLAST  = (hs == rlast_at);
      @(negedge ACLK);
      chk("data_state", 64'({bus.BUSY, bus.R_OWNER, bus.R_SEL, bus.ARVALID_S,
                             bus.ARREADY_M1, bus.ARREADY_M0, bus.LEN_ERR}),
          64'({1'b1, w[0], sel[2:0], 7'd0, 1'b0, 1'b0, 1'b0}));
      if (bus.RVALID && bus.RREADY) begin
        if (bus.RLAST) done = 1'b1;
        hs++;
      end
      step();
      cycles++;
    end
    chk("data_rlast_seen", 64'(done), 64'd1);
    last_winner = w;
    exp_err = ((rlast_at % 16) != int'(f_len[w]));
    bus.RVALID = 1'b0; bus.RREADY = 1'b0; bus.RLAST = 1'b0;
    bus.ARVALID_M0 = 1'b0; bus.ARVALID_M1 = 1'b0;
    @(negedge ACLK);
    chk("post_busy", 64'(bus.BUSY), 64'd0);
    chk("post_len_err", 64'(bus.LEN_ERR), 64'(exp_err));
    step();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int r, len, m0a, m1a;
    drive_idle();
    ARESET = 1'b1;
    last_winner = 1;
    step();
    @(negedge ACLK);
    chk("reset_busy", 64'(bus.BUSY), 64'd0);
    chk("reset_arvalid_s", 64'(bus.ARVALID_S), 64'd0);
    chk("reset_outputs", 64'({bus.ARREADY_M1, bus.ARREADY_M0, bus.LEN_ERR, bus.R_OWNER, bus.R_SEL}), 64'd0);
    chk("reset_payload", 64'(dut_payload()), 64'd0);
    ARESET = 1'b0;
    step();

    // single M0 read to S1
    set_m(0, 4'h5, 32'h0001_0040, 4'd0);
    set_m(1, 4'h9, 32'h0000_0100, 4'd0);
    burst(1'b1, 1'b0, 0, 0, -1);

    // simultaneous requests after reset alternate M0, M1, M0
    do_reset();
    set_m(0, 4'h1, 32'h0000_2000, 4'd1);
    set_m(1, 4'h2, 32'h0002_0010, 4'd2);
    burst(1'b1, 1'b1, 0, 1, -1);
    burst(1'b1, 1'b1, 1, 2, -1);
    burst(1'b1, 1'b1, 0, 1, -1);

    // unmapped address goes to the default slave
    set_m(1, 4'hA, 32'h3000_0000, 4'd0);
    burst(1'b0, 1'b1, 1, 0, -1);

    // S5 burst with correct and early RLAST
    set_m(1, 4'h3, 32'h2000_1000, 4'd3);
    burst(1'b0, 1'b1, 0, 3, -1);
    burst(1'b0, 1'b1, 0, 1, -1);

    // slave stalls five cycles while the other master keeps requesting
    set_m(0, 4'h7, 32'h1000_0200, 4'd2);
    set_m(1, 4'h8, 32'h1001_0000, 4'd0);
    burst(1'b1, 1'b1, 5, 2, -1);

    // beat counter wraps: 18 beats with ARLEN=1 lands back on index 1
    set_m(0, 4'h4, 32'h0001_8000, 4'd1);
    burst(1'b1, 1'b0, 0, 17, -1);

    // reset in the middle of a burst, then normal traffic resumes
    set_m(0, 4'hC, 32'h2010_0000, 4'd7);
    burst(1'b1, 1'b0, 0, 7, 2);
    set_m(0, 4'hD, 32'h1000_0004, 4'd0);
    set_m(1, 4'hE, 32'h0002_0000, 4'd1);
    burst(1'b1, 1'b1, 2, 0, -1);

    for (int n = 0; n < 24; n++) begin
      r   = int'($urandom_range(1, 3));
      m0a = int'($urandom_range(0, 18));
      m1a = int'($urandom_range(0, 18));
      len = int'($urandom_range(0, 15));
      set_m(0, 4'($urandom), (m0a == 18) ? 32'($urandom) : addr_tab[m0a], 4'(len));
      set_m(1, 4'($urandom), (m1a == 18) ? 32'($urandom) : addr_tab[m1a], 4'(len));
      burst(r[0], r[1], int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 17)) : len, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
